// File: rtl/lpc_txn_logger.sv
// rtl/lpc_txn_logger.sv - LPC I/O transaction capture FIFO with 4-byte record stream drain

// Record queue: one entry per captured transaction, level carries an extra bit
// so all DEPTH slots are usable and full/empty need no sacrificed entry.
module lpc_txn_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 25
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pushValid,
  input  logic [WIDTH-1:0]         pushData,
  output logic                     pushAccept,
  input  logic                     popReq,
  output logic [WIDTH-1:0]         popData,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   levelNext
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             full;
  logic             doPop;

  assign full       = level[AW];
  assign empty      = (level == '0);
  assign doPop      = popReq && !empty;
  // a full queue still takes a push when the drain side frees a slot this cycle
  assign pushAccept = pushValid && (!full || doPop);
  assign popData    = mem[rdPtr];

  // next occupancy, shared with the top so busy can be registered alongside it
  always_comb begin
    levelNext = level;
    if (pushAccept && !doPop) begin
      levelNext = level + LW'(1);
    end else if (!pushAccept && doPop) begin
      levelNext = level - LW'(1);
    end
  end

  // entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (pushAccept) begin
      mem[wrPtr] <= pushData;
    end
  end

  // pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (pushAccept) wrPtr <= wrPtr + AW'(1);
      if (doPop)      rdPtr <= rdPtr + AW'(1);
      level <= levelNext;
    end
  end
endmodule

// Top: address-window filter, overflow counter and record serializer.
module lpc_txn_logger #(
  parameter int          DEPTH     = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] ADDR_MASK = 16'h0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              addr,
  input  logic [7:0]               wrData,
  input  logic [7:0]               rdData,
  input  logic                     didWrite,
  input  logic                     didRead,
  input  logic                     enableLog,
  input  logic                     clearOverflow,
  output logic [7:0]               streamData,
  output logic                     streamValid,
  input  logic                     streamReady,
  output logic [7:0]               overflowCount,
  output logic [$clog2(DEPTH):0]   fifoLevel,
  output logic                     busy
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    ADDR_HI = 3'd2,
    ADDR_LO = 3'd3,
    DATA    = 3'd4
  } drainState_t;

  drainState_t state;
  drainState_t stateNext;

  logic                   qualify;
  logic                   wantPush;
  logic [24:0]            pushEntry;
  logic                   pushAccept;
  logic                   popReq;
  logic [24:0]            popData;
  logic                   fifoEmpty;
  logic [$clog2(DEPTH):0] levelNext;
  logic                   dropRead;
  logic                   dropFull;
  logic [1:0]             dropCount;
  logic [8:0]             ovSum;
  logic [23:0]            shadow;
  logic [7:0]             dataNext;
  logic                   handshake;

  assign qualify   = enableLog && ((addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
  assign wantPush  = qualify && (didWrite || didRead);
  // a write wins over a simultaneous read
  assign pushEntry = didWrite ? {1'b1, addr, wrData} : {1'b0, addr, rdData};
  assign dropRead  = qualify && didWrite && didRead;
  assign dropFull  = wantPush && !pushAccept;
  assign dropCount = {1'b0, dropRead} + {1'b0, dropFull};
  assign ovSum     = {1'b0, overflowCount} + {7'd0, dropCount};
  assign handshake = streamValid && streamReady;

  lpc_txn_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (25)
  ) fifo (
    .clk        (clk),
    .reset      (reset),
    .pushValid  (wantPush),
    .pushData   (pushEntry),
    .pushAccept (pushAccept),
    .popReq     (popReq),
    .popData    (popData),
    .empty      (fifoEmpty),
    .level      (fifoLevel),
    .levelNext  (levelNext)
  );

  // drop counter; a clear coinciding with drops restarts from those drops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflowCount <= 8'd0;
    end else if (clearOverflow) begin
      overflowCount <= {6'd0, dropCount};
    end else if (ovSum[8]) begin
      overflowCount <= 8'hFF;
    end else begin
      overflowCount <= ovSum[7:0];
    end
  end

  // drain sequencing and the byte to present after the next edge
  always_comb begin
    stateNext = state;
    popReq    = 1'b0;
    dataNext  = streamData;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          popReq    = 1'b1;
          stateNext = HDR;
          dataNext  = popData[24] ? 8'hA1 : 8'hA2;
        end
      end
      HDR: begin
        if (handshake) begin
          stateNext = ADDR_HI;
          dataNext  = shadow[23:16];
        end
      end
      ADDR_HI: begin
        if (handshake) begin
          stateNext = ADDR_LO;
          dataNext  = shadow[15:8];
        end
      end
      ADDR_LO: begin
        if (handshake) begin
          stateNext = DATA;
          dataNext  = shadow[7:0];
        end
      end
      DATA: begin
        if (handshake) begin
          if (!fifoEmpty) begin
            popReq    = 1'b1;
            stateNext = HDR;
            dataNext  = popData[24] ? 8'hA1 : 8'hA2;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // registered stream outputs, shadow record and busy flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      streamValid <= 1'b0;
      streamData  <= 8'd0;
      shadow      <= 24'd0;
      busy        <= 1'b0;
    end else begin
      state       <= stateNext;
      streamValid <= (stateNext != IDLE);
      streamData  <= dataNext;
      if (popReq) shadow <= popData[23:0];
      busy        <= (stateNext != IDLE) || (levelNext != '0);
    end
  end
endmodule

// File: tb/tb_lpc_txn_logger.sv
// tb/tb_lpc_txn_logger.sv - randomized and directed bench for lpc_txn_logger
module tb_lpc_txn_logger;
  localparam int DEPTH = 16;

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  wrData;
  logic [7:0]  rdData;
  logic        didWrite;
  logic        didRead;
  logic        enableLog;
  logic        clearOverflow;
  logic        streamReady;
  logic [7:0]  sdA  [2];
  logic        svA  [2];
  logic [7:0]  ovA  [2];
  logic [4:0]  lvlA [2];
  logic        busyA[2];

  lpc_txn_logger #(.DEPTH(DEPTH), .BASE_ADDR(16'h0000), .ADDR_MASK(16'h0000)) dutAll (
    .clk(clk), .reset(reset), .addr(addr), .wrData(wrData), .rdData(rdData),
    .didWrite(didWrite), .didRead(didRead), .enableLog(enableLog),
    .clearOverflow(clearOverflow), .streamData(sdA[0]), .streamValid(svA[0]),
    .streamReady(streamReady), .overflowCount(ovA[0]), .fifoLevel(lvlA[0]), .busy(busyA[0])
  );

  lpc_txn_logger #(.DEPTH(DEPTH), .BASE_ADDR(16'h0080), .ADDR_MASK(16'hFFF0)) dutWin (
    .clk(clk), .reset(reset), .addr(addr), .wrData(wrData), .rdData(rdData),
    .didWrite(didWrite), .didRead(didRead), .enableLog(enableLog),
    .clearOverflow(clearOverflow), .streamData(sdA[1]), .streamValid(svA[1]),
    .streamReady(streamReady), .overflowCount(ovA[1]), .fifoLevel(lvlA[1]), .busy(busyA[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;

  // reference model: queued records, record in flight with bytes left, drop count
  logic [24:0] mq   [2][64];
  int          mHead[2];
  int          mCount[2];
  logic [24:0] mCur [2];
  int          mLeft[2];
  int          mOv  [2];

  // bytes seen on one selected instance's stream
  int          logSel = 0;
  int          logN   = 0;
  logic [7:0]  logB [64];
  int          logC [64];

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit inWindow(input int i, input logic [15:0] a);
    return (i == 0) ? 1'b1 : ((a & 16'hFFF0) == 16'h0080);
  endfunction

  function automatic logic [7:0] expByte(input int i);
    case (mLeft[i])
      4:       return mCur[i][24] ? 8'hA1 : 8'hA2;
      3:       return mCur[i][23:16];
      2:       return mCur[i][15:8];
      default: return mCur[i][7:0];
    endcase
  endfunction

  task automatic modelReset(input int i);
    mHead[i] = 0; mCount[i] = 0; mLeft[i] = 0; mOv[i] = 0; mCur[i] = '0;
  endtask

  task automatic modelEdge(input int i);
    bit   hs, pop;
    int   drops, pre;
    logic [24:0] rec;
    hs    = (mLeft[i] > 0) && streamReady;
    pop   = (mCount[i] > 0) && (mLeft[i] == 0 || (hs && mLeft[i] == 1));
    pre   = mCount[i];
    drops = 0;
    if (pop) begin
      mCur[i]   = mq[i][mHead[i]];
      mHead[i]  = (mHead[i] + 1) % 64;
      mCount[i] = mCount[i] - 1;
      mLeft[i]  = 4;
    end else if (hs) begin
      mLeft[i] = mLeft[i] - 1;
    end
    if (enableLog && inWindow(i, addr) && (didWrite || didRead)) begin
      if (didWrite && didRead) drops++;
      rec = didWrite ? {1'b1, addr, wrData} : {1'b0, addr, rdData};
      if (pre < DEPTH || pop) begin
        mq[i][(mHead[i] + mCount[i]) % 64] = rec;
        mCount[i] = mCount[i] + 1;
      end else begin
        drops++;
      end
    end
    if (clearOverflow) mOv[i] = drops;
    else               mOv[i] = (mOv[i] + drops > 255) ? 255 : mOv[i] + drops;
  endtask

  task automatic step();
    if (!reset) begin
      for (int i = 0; i < 2; i++)
        if (mLeft[i] > 0 && streamReady)
          checkEq($sformatf("byte%0d", i), sdA[i], expByte(i));
      if (svA[logSel] && streamReady && logN < 64) begin
        logB[logN] = sdA[logSel];
        logC[logN] = cyc;
        logN++;
      end
      for (int i = 0; i < 2; i++) modelEdge(i);
    end else begin
      for (int i = 0; i < 2; i++) modelReset(i);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      checkEq($sformatf("valid%0d", i), svA[i], mLeft[i] > 0);
      checkEq($sformatf("level%0d", i), lvlA[i], mCount[i]);
      checkEq($sformatf("ovf%0d", i), ovA[i], mOv[i]);
      checkEq($sformatf("busy%0d", i), busyA[i], (mCount[i] > 0) || (mLeft[i] > 0));
    end
  endtask

  task automatic strobe(input logic w, input logic r, input logic [15:0] a,
                        input logic [7:0] wd, input logic [7:0] rd);
    didWrite = w; didRead = r; addr = a; wrData = wd; rdData = rd;
    step();
    didWrite = 1'b0; didRead = 1'b0;
  endtask

  task automatic drainAll(input int bound);
    int n;
    n = 0;
    while ((busyA[0] || busyA[1]) && n < bound) begin
      step();
      n++;
    end
    checkEq("drain_done", {busyA[1], busyA[0]}, 0);
  endtask

  task automatic checkLog(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3, input int base);
    checkEq({tag, "_b0"}, logB[base],     b0);
    checkEq({tag, "_b1"}, logB[base + 1], b1);
    checkEq({tag, "_b2"}, logB[base + 2], b2);
    checkEq({tag, "_b3"}, logB[base + 3], b3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ovBefore, n;
    reset = 1'b1; addr = '0; wrData = '0; rdData = '0; didWrite = 0; didRead = 0;
    enableLog = 1'b1; clearOverflow = 1'b0; streamReady = 1'b1;
    for (int i = 0; i < 2; i++) modelReset(i);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checkEq("rst_data",  sdA[i], 0);
      checkEq("rst_valid", svA[i], 0);
      checkEq("rst_ovf",   ovA[i], 0);
      checkEq("rst_level", lvlA[i], 0);
      checkEq("rst_busy",  busyA[i], 0);
    end
    reset = 1'b0;

    // write capture and latency
    logSel = 0; logN = 0;
    strobe(1, 0, 16'h2468, 8'h9E, 8'h00);
    checkEq("wr_level_after_strobe", lvlA[0], 1);
    checkEq("wr_no_hdr_yet", svA[0], 0);
    step();
    checkEq("wr_hdr_valid", svA[0], 1);
    checkEq("wr_hdr_byte", sdA[0], 8'hA1);
    checkEq("wr_level_after_pop", lvlA[0], 0);
    repeat (4) step();
    checkEq("wr_busy_cleared", busyA[0], 0);
    checkEq("wr_nbytes", logN, 4);
    checkLog("wr", 8'hA1, 8'h24, 8'h68, 8'h9E, 0);

    // back-to-back reads
    logN = 0;
    strobe(0, 1, 16'h1234, 8'h00, 8'hAB);
    strobe(0, 1, 16'h5678, 8'h00, 8'hCD);
    repeat (10) step();
    checkEq("rd_nbytes", logN, 8);
    checkLog("rd0", 8'hA2, 8'h12, 8'h34, 8'hAB, 0);
    checkLog("rd1", 8'hA2, 8'h56, 8'h78, 8'hCD, 4);
    checkEq("rd_no_bubble", logC[7] - logC[0], 7);

    // backpressure, ready toggling
    streamReady = 1'b0;
    strobe(1, 0, 16'h0081, 8'h11, 8'h00);
    strobe(1, 0, 16'h0082, 8'h22, 8'h00);
    n = 0;
    while (!svA[0] && n < 10) begin step(); n++; end
    logN = 0;
    for (int k = 0; k < 16; k++) begin
      streamReady = k[0];
      step();
    end
    checkEq("bp_nbytes", logN, 8);
    checkLog("bp0", 8'hA1, 8'h00, 8'h81, 8'h11, 0);
    checkLog("bp1", 8'hA1, 8'h00, 8'h82, 8'h22, 4);
    streamReady = 1'b1;
    drainAll(50);

    // overflow and saturation with the sink stalled
    streamReady = 1'b0;
    for (int k = 0; k < 16; k++) strobe(1, 0, 16'h0100 + 16'(k), 8'(k), 8'h00);
    checkEq("ovf_level15", lvlA[0], 15);
    checkEq("ovf_none_yet", ovA[0], 0);
    strobe(1, 0, 16'h0110, 8'h10, 8'h00);
    checkEq("ovf_level_full", lvlA[0], DEPTH);
    checkEq("ovf_still_none", ovA[0], 0);
    for (int k = 0; k < 3; k++) strobe(1, 0, 16'h0120, 8'h00, 8'h00);
    checkEq("ovf_three", ovA[0], 3);
    for (int k = 0; k < 300; k++) strobe(1, 0, 16'h0130, 8'h00, 8'h00);
    checkEq("ovf_saturate", ovA[0], 255);
    clearOverflow = 1'b1;
    strobe(1, 0, 16'h0140, 8'h00, 8'h00);
    checkEq("ovf_clear_with_drop", ovA[0], 1);
    step();
    checkEq("ovf_clear_alone", ovA[0], 0);
    clearOverflow = 1'b0;
    streamReady = 1'b1;
    drainAll(200);

    // address window, enable and simultaneous strobes on the windowed instance
    logSel = 1; logN = 0;
    strobe(1, 0, 16'h0085, 8'h55, 8'h00);
    strobe(1, 0, 16'h0090, 8'h66, 8'h00);
    drainAll(50);
    checkEq("win_nbytes", logN, 4);
    checkLog("win", 8'hA1, 8'h00, 8'h85, 8'h55, 0);
    logN = 0;
    ovBefore = ovA[1];
    enableLog = 1'b0;
    strobe(1, 0, 16'h0085, 8'h77, 8'h00);
    repeat (4) step();
    checkEq("dis_nbytes", logN, 0);
    checkEq("dis_no_count", ovA[1], ovBefore);
    enableLog = 1'b1;
    strobe(1, 1, 16'h0086, 8'h77, 8'h88);
    checkEq("both_ovf", ovA[1], ovBefore + 1);
    drainAll(50);
    checkEq("both_nbytes", logN, 4);
    checkLog("both", 8'hA1, 8'h00, 8'h86, 8'h77, 0);

    // reset during ADDR_LO with a record still queued
    logSel = 0;
    strobe(1, 0, 16'h0084, 8'h99, 8'h00);
    strobe(1, 0, 16'h0085, 8'h9A, 8'h00);
    step();
    step();
    checkEq("mid_addr_lo_byte", sdA[0], 8'h84);
    checkEq("mid_queued", lvlA[0], 1);
    #3;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) modelReset(i);
    #1;
    checkEq("mid_rst_valid", svA[0], 0);
    checkEq("mid_rst_level", lvlA[0], 0);
    step();
    reset = 1'b0;
    logN = 0;
    strobe(1, 0, 16'h0087, 8'h5A, 8'h00);
    repeat (5) step();
    checkEq("post_rst_nbytes", logN, 4);
    checkLog("post_rst", 8'hA1, 8'h00, 8'h87, 8'h5A, 0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      didWrite      = ($urandom % 4) == 0;
      didRead       = ($urandom % 5) == 0;
      addr          = ($urandom % 2) ? (16'h0080 | 16'($urandom % 32)) : 16'($urandom);
      wrData        = 8'($urandom);
      rdData        = 8'($urandom);
      enableLog     = ($urandom % 8) != 0;
      clearOverflow = ($urandom % 40) == 0;
      streamReady   = ((c / 150) % 2 == 1) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
      step();
    end
    didWrite = 0; didRead = 0; clearOverflow = 0; streamReady = 1'b1;
    drainAll(500);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
